// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 registered demultiplexer.
package demux_pkg;
   localparam int NUM_OUT = 8;
   localparam int SEL_W   = 3;

   typedef logic [SEL_W-1:0] sel_t;
endpackage : demux_pkg

// File: rtl/decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; mask is all zeros when disabled.
module decoder_3to8
   import demux_pkg::*;
(
   input  sel_t               sel_i,
   input  logic               en_i,
   output logic [NUM_OUT-1:0] mask_o
);

   // Every select code is listed so no code falls through to an X or stale lane.
   always_comb begin
      mask_o = '0;
      if (en_i) begin
         case (sel_i)
            3'd0:    mask_o = 8'b0000_0001;
            3'd1:    mask_o = 8'b0000_0010;
            3'd2:    mask_o = 8'b0000_0100;
            3'd3:    mask_o = 8'b0000_1000;
            3'd4:    mask_o = 8'b0001_0000;
            3'd5:    mask_o = 8'b0010_0000;
            3'd6:    mask_o = 8'b0100_0000;
            3'd7:    mask_o = 8'b1000_0000;
            default: mask_o = '0;
         endcase
      end
   end

endmodule : decoder_3to8

// File: rtl/demux_8x1_sync.sv
// 1-to-8 demultiplexer with registered outputs: the selected lane loads data,
// all other lanes load zero, with one clock of latency.
module demux_8x1_sync
   import demux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] data,
   input  logic             sel0,
   input  logic             sel1,
   input  logic             sel2,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic [WIDTH-1:0] y4,
   output logic [WIDTH-1:0] y5,
   output logic [WIDTH-1:0] y6,
   output logic [WIDTH-1:0] y7
);

   sel_t                            sel;
   logic [NUM_OUT-1:0]              lane_mask;
   logic [NUM_OUT-1:0][WIDTH-1:0]   y_d;
   logic [NUM_OUT-1:0][WIDTH-1:0]   y_q;

   assign sel = {sel2, sel1, sel0};

   decoder_3to8 u_dec (
      .sel_i  (sel),
      .en_i   (en),
      .mask_o (lane_mask)
   );

   // Gate data into each lane by its mask bit; unselected lanes see zero.
   always_comb begin
      y_d = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         y_d[k] = lane_mask[k] ? data : '0;
      end
   end

   // Register bank: reset wins over everything, otherwise all lanes update together.
   always_ff @(posedge clk) begin
      if (!rst_n) y_q <= '0;
      else        y_q <= y_d;
   end

   assign y0 = y_q[0];
   assign y1 = y_q[1];
   assign y2 = y_q[2];
   assign y3 = y_q[3];
   assign y4 = y_q[4];
   assign y5 = y_q[5];
   assign y6 = y_q[6];
   assign y7 = y_q[7];

endmodule : demux_8x1_sync

// File: tb/tb_demux_8x1_sync.sv
// Directed self-checking bench for demux_8x1_sync (WIDTH = 1).
module tb_demux_8x1_sync;

   localparam int W = 1;

   logic         clk = 1'b0;
   logic         rst_n, en, sel0, sel1, sel2;
   logic [W-1:0] data;
   logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;

   int total = 0;
   int fails = 0;

   demux_8x1_sync #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .data  (data),
      .sel0  (sel0),
      .sel1  (sel1),
      .sel2  (sel2),
      .y0    (y0),
      .y1    (y1),
      .y2    (y2),
      .y3    (y3),
      .y4    (y4),
      .y5    (y5),
      .y6    (y6),
      .y7    (y7)
   );

   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running, expected finished");
      $fatal(1, "timeout");
   end

   task automatic set_sel(input int s);
      sel0 = s[0];
      sel1 = s[1];
      sel2 = s[2];
   endtask

   // Advance one rising edge and sample just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] exp);
      logic [7:0] obs;
      obs = {y7, y6, y5, y4, y3, y2, y1, y0};
      total++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] onehot;

      // Reset holds all outputs at zero even with a live selection.
      rst_n = 1'b0; en = 1'b1; data = 1'b1; set_sel(5);
      tick(); check("reset_edge1", 8'b0000_0000);
      tick(); check("reset_edge2", 8'b0000_0000);
      rst_n = 1'b1;
      tick(); check("reset_release_y5", 8'b0010_0000);

      // Sweep all eight lanes with data 0 then 1.
      for (int s = 0; s < 8; s++) begin
         set_sel(s);
         data = 1'b0;
         tick(); check($sformatf("sweep_s%0d_d0", s), 8'b0000_0000);
         data = 1'b1;
         onehot = 8'b0000_0001 << s;
         tick(); check($sformatf("sweep_s%0d_d1", s), onehot);
      end

      // Lane switch: old lane clears on the same edge the new one loads.
      set_sel(2); data = 1'b1;
      tick(); check("switch_y2", 8'b0000_0100);
      set_sel(6);
      tick(); check("switch_y6", 8'b0100_0000);

      // Enable low forces zero, raising it restores the lane.
      set_sel(3); data = 1'b1; en = 1'b0;
      tick(); check("en_low", 8'b0000_0000);
      en = 1'b1;
      tick(); check("en_high_y3", 8'b0000_1000);

      // Select change mid-cycle is invisible until the next edge.
      set_sel(0); data = 1'b1;
      tick(); check("lat_y0", 8'b0000_0001);
      #3 set_sel(7);
      #1 check("lat_hold_y0", 8'b0000_0001);
      tick(); check("lat_y7", 8'b1000_0000);

      // Mid-run reset pulse.
      set_sel(4); data = 1'b1;
      tick(); check("mid_y4", 8'b0001_0000);
      rst_n = 1'b0;
      tick(); check("mid_reset", 8'b0000_0000);
      rst_n = 1'b1;
      tick(); check("mid_release_y4", 8'b0001_0000);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule : tb_demux_8x1_sync

// File: doc/demux_8x1_sync.md
Name: demux_8x1_sync

Overview:
- 1-to-8 demultiplexer with registered outputs. Routes one data input to one of eight outputs, chosen by a 3-bit select formed from three discrete select pins.
- Sits between a single-source producer and eight consumer lanes. Gives glitch-free, clock-aligned one-of-eight steering.
- All non-selected outputs are driven to zero.

Parameters:
- WIDTH, 1, bit width of the data input and of each output.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- en  input  1  steering enable; when low, all outputs are forced to zero on the next edge.
- data  input  WIDTH  value to be routed.
- sel0  input  1  select bit 0 (LSB).
- sel1  input  1  select bit 1.
- sel2  input  1  select bit 2 (MSB).
- y0..y7  output  WIDTH each  demux outputs; yN carries data when the select index equals N.

Behaviour:
- Select index S = {sel2, sel1, sel0}, an unsigned value 0..7.
- Reset: on a rising clk edge with rst_n = 0, y0..y7 all load zero. Reset has priority over en, data and selects.
- Reset asserted mid-stream clears all outputs on that edge. On the first edge after rst_n returns high, the outputs reflect the inputs sampled at that edge.
- Normal operation (rst_n = 1, en = 1), on each rising edge:
  - yS <= data.
  - Every yK with K != S <= 0.
- Disabled (rst_n = 1, en = 0): all y0..y7 <= 0 on the edge.
- Latency: exactly one clock. Outputs change only on a rising clk edge and are otherwise stable.
- Exactly one output may be non-zero in any cycle. data = 0 routed to yS yields all outputs zero.
- Select changes take effect on the same edge as data, so there is no stale-lane carry-over. The previously selected lane clears in the same cycle the new lane loads.
- No X propagation by design: the decoder covers all 8 select codes and has no default-hole.
- Width rule: data is copied bit-exactly. No sign extension and no arithmetic.

Decomposition:
- Shared package demux_pkg holds:
  - NUM_OUT = 8
  - SEL_W = 3
  - a typedef for the select index (logic [SEL_W-1:0])
- One sub-module is natural: decoder_3to8. It is purely combinational, mapping the 3-bit select plus en to an 8-bit one-hot lane mask (all zeros when en = 0).
- The top level then ANDs data with each mask bit into a per-lane register bank under synchronous active-low reset.

Test Plan:
- Reset: hold rst_n = 0 with en = 1, data = 1, S = 5 for 2 edges -> all y0..y7 = 0. Release rst_n -> after 1 edge, y5 = 1 and the others = 0.
- Full sweep: rst_n = 1, en = 1. For S = 0..7, apply data = 0 then data = 1, each held for one or more edges -> on the following edge yS = data and the other seven = 0. This gives 16 checks total.
- Lane switch: S = 2 with data = 1 for one edge, then S = 6 with data = 1 -> after the second edge y2 = 0 and y6 = 1 in the same cycle.
- Enable: S = 3, data = 1, en = 0 -> all outputs 0 after the edge. Raise en -> y3 = 1 after the next edge.
- Latency: change S from 0 to 7 mid-cycle with data = 1 -> outputs remain y0 = 1 until the next rising edge, then y7 = 1 and y0 = 0.
- Mid-run reset: while y4 = 1, pulse rst_n low for one edge -> all outputs 0 on that edge. y4 returns to 1 one edge after release if the inputs are unchanged.
